// File: rtl/ft_pkg.sv
// rtl/ft_pkg.sv - shared types and defaults for the fault-tolerant compressed decoder
// Contents: cdec_mode_e degradation modes, CDEC_NMR_* parameter defaults,
//           RV32 major opcodes used by the expander, healthy-count to mode mapping.
package ft_pkg;

    typedef enum logic [1:0] {
        CDEC_VOTE    = 2'b00,
        CDEC_COMPARE = 2'b01,
        CDEC_SIMPLEX = 2'b10,
        CDEC_FAIL    = 2'b11
    } cdec_mode_e;

    localparam int CDEC_NMR_N_REP              = 3;
    localparam int CDEC_NMR_COUNT_BIT          = 4;
    localparam int CDEC_NMR_INCREMENT          = 2;
    localparam int CDEC_NMR_DECREMENT          = 1;
    localparam int CDEC_NMR_BREAKING_THRESHOLD = 8;

    localparam logic [6:0] OPCODE_LOAD     = 7'h03;
    localparam logic [6:0] OPCODE_LOAD_FP  = 7'h07;
    localparam logic [6:0] OPCODE_OPIMM    = 7'h13;
    localparam logic [6:0] OPCODE_STORE    = 7'h23;
    localparam logic [6:0] OPCODE_STORE_FP = 7'h27;
    localparam logic [6:0] OPCODE_OP       = 7'h33;
    localparam logic [6:0] OPCODE_LUI      = 7'h37;
    localparam logic [6:0] OPCODE_BRANCH   = 7'h63;
    localparam logic [6:0] OPCODE_JALR     = 7'h67;
    localparam logic [6:0] OPCODE_JAL      = 7'h6f;

    function automatic cdec_mode_e cdec_mode_from_healthy(input int unsigned healthy);
        if (healthy >= 3)      return CDEC_VOTE;
        else if (healthy == 2) return CDEC_COMPARE;
        else if (healthy == 1) return CDEC_SIMPLEX;
        else                   return CDEC_FAIL;
    endfunction

endpackage

// File: rtl/cv32e40p_compressed_decoder.sv
// rtl/cv32e40p_compressed_decoder.sv - RV32C to RV32I instruction expander
// Ports: instr_i (fetched word), instr_o (expanded word),
//        is_compressed_o (low bits != 2'b11), illegal_instr_o (reserved/unsupported encoding).
module cv32e40p_compressed_decoder
    import ft_pkg::*;
#(
    parameter int FPU = 0
) (
    input  logic [31:0] instr_i,
    output logic [31:0] instr_o,
    output logic        is_compressed_o,
    output logic        illegal_instr_o
);

    localparam bit HAS_FPU = (FPU != 0);

    assign is_compressed_o = (instr_i[1:0] != 2'b11);

    always_comb begin
        illegal_instr_o = 1'b0;
        instr_o         = '0;
        case (instr_i[1:0])
            2'b00: begin
                case (instr_i[15:13])
                    3'b000: begin // c.addi4spn; a zero immediate is reserved
                        instr_o = {2'b0, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00,
                                   5'h02, 3'b000, 2'b01, instr_i[4:2], OPCODE_OPIMM};
                        if (instr_i[12:5] == 8'h00) illegal_instr_o = 1'b1;
                    end
                    3'b001: begin // c.fld
                        instr_o = {4'b0, instr_i[6:5], instr_i[12:10], 3'b000, 2'b01, instr_i[9:7],
                                   3'b011, 2'b01, instr_i[4:2], OPCODE_LOAD_FP};
                        illegal_instr_o = !HAS_FPU;
                    end
                    3'b010: begin // c.lw
                        instr_o = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00, 2'b01, instr_i[9:7],
                                   3'b010, 2'b01, instr_i[4:2], OPCODE_LOAD};
                    end
                    3'b011: begin // c.flw
                        instr_o = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00, 2'b01, instr_i[9:7],
                                   3'b010, 2'b01, instr_i[4:2], OPCODE_LOAD_FP};
                        illegal_instr_o = !HAS_FPU;
                    end
                    3'b101: begin // c.fsd
                        instr_o = {4'b0, instr_i[6:5], instr_i[12], 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                   3'b011, instr_i[11:10], 3'b000, OPCODE_STORE_FP};
                        illegal_instr_o = !HAS_FPU;
                    end
                    3'b110: begin // c.sw
                        instr_o = {5'b0, instr_i[5], instr_i[12], 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                   3'b010, instr_i[11:10], instr_i[6], 2'b00, OPCODE_STORE};
                    end
                    3'b111: begin // c.fsw
                        instr_o = {5'b0, instr_i[5], instr_i[12], 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                   3'b010, instr_i[11:10], instr_i[6], 2'b00, OPCODE_STORE_FP};
                        illegal_instr_o = !HAS_FPU;
                    end
                    default: illegal_instr_o = 1'b1;
                endcase
            end
            2'b01: begin
                case (instr_i[15:13])
                    3'b000: begin // c.addi
                        instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], instr_i[11:7], 3'b000,
                                   instr_i[11:7], OPCODE_OPIMM};
                    end
                    3'b001, 3'b101: begin // c.jal (rd=ra) / c.j (rd=x0)
                        instr_o = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6], instr_i[7], instr_i[2],
                                   instr_i[11], instr_i[5:3], {9{instr_i[12]}}, 4'b0, ~instr_i[15], OPCODE_JAL};
                    end
                    3'b010: begin // c.li
                        instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 5'b0, 3'b000,
                                   instr_i[11:7], OPCODE_OPIMM};
                    end
                    3'b011: begin // c.addi16sp when rd=sp, otherwise c.lui
                        if (instr_i[11:7] == 5'h02) begin
                            instr_o = {{3{instr_i[12]}}, instr_i[4:3], instr_i[5], instr_i[2], instr_i[6], 4'b0,
                                       5'h02, 3'b000, 5'h02, OPCODE_OPIMM};
                        end else begin
                            instr_o = {{15{instr_i[12]}}, instr_i[6:2], instr_i[11:7], OPCODE_LUI};
                        end
                        if ({instr_i[12], instr_i[6:2]} == 6'b0) illegal_instr_o = 1'b1;
                    end
                    3'b100: begin
                        case (instr_i[11:10])
                            2'b00, 2'b01: begin // c.srli / c.srai; shamt[5] must be zero on RV32
                                instr_o = {1'b0, instr_i[10], 5'b0, instr_i[6:2], 2'b01, instr_i[9:7], 3'b101,
                                           2'b01, instr_i[9:7], OPCODE_OPIMM};
                                if (instr_i[12]) illegal_instr_o = 1'b1;
                            end
                            2'b10: begin // c.andi
                                instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 2'b01, instr_i[9:7],
                                           3'b111, 2'b01, instr_i[9:7], OPCODE_OPIMM};
                            end
                            default: begin // c.sub / c.xor / c.or / c.and
                                case ({instr_i[12], instr_i[6:5]})
                                    3'b000: instr_o = {2'b01, 5'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                                       3'b000, 2'b01, instr_i[9:7], OPCODE_OP};
                                    3'b001: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                                       3'b100, 2'b01, instr_i[9:7], OPCODE_OP};
                                    3'b010: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                                       3'b110, 2'b01, instr_i[9:7], OPCODE_OP};
                                    3'b011: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                                       3'b111, 2'b01, instr_i[9:7], OPCODE_OP};
                                    default: illegal_instr_o = 1'b1;
                                endcase
                            end
                        endcase
                    end
                    default: begin // c.beqz / c.bnez, funct3 bit 0 taken from instr_i[13]
                        instr_o = {{4{instr_i[12]}}, instr_i[6:5], instr_i[2], 5'b0, 2'b01, instr_i[9:7],
                                   2'b00, instr_i[13], instr_i[11:10], instr_i[4:3], instr_i[12], OPCODE_BRANCH};
                    end
                endcase
            end
            2'b10: begin
                case (instr_i[15:13])
                    3'b000: begin // c.slli
                        instr_o = {7'b0, instr_i[6:2], instr_i[11:7], 3'b001, instr_i[11:7], OPCODE_OPIMM};
                        if (instr_i[12]) illegal_instr_o = 1'b1;
                    end
                    3'b001: begin // c.fldsp
                        instr_o = {3'b0, instr_i[4:2], instr_i[12], instr_i[6:5], 3'b000, 5'h02, 3'b011,
                                   instr_i[11:7], OPCODE_LOAD_FP};
                        illegal_instr_o = !HAS_FPU;
                    end
                    3'b010: begin // c.lwsp; rd=x0 is reserved
                        instr_o = {4'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00, 5'h02, 3'b010,
                                   instr_i[11:7], OPCODE_LOAD};
                        if (instr_i[11:7] == 5'b0) illegal_instr_o = 1'b1;
                    end
                    3'b011: begin // c.flwsp
                        instr_o = {4'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00, 5'h02, 3'b010,
                                   instr_i[11:7], OPCODE_LOAD_FP};
                        illegal_instr_o = !HAS_FPU;
                    end
                    3'b100: begin
                        if (!instr_i[12]) begin
                            if (instr_i[6:2] != 5'b0) begin // c.mv
                                instr_o = {7'b0, instr_i[6:2], 5'b0, 3'b000, instr_i[11:7], OPCODE_OP};
                            end else begin // c.jr; rs1=x0 is reserved
                                instr_o = {12'b0, instr_i[11:7], 3'b000, 5'b0, OPCODE_JALR};
                                if (instr_i[11:7] == 5'b0) illegal_instr_o = 1'b1;
                            end
                        end else begin
                            if (instr_i[6:2] != 5'b0) begin // c.add
                                instr_o = {7'b0, instr_i[6:2], instr_i[11:7], 3'b000, instr_i[11:7], OPCODE_OP};
                            end else if (instr_i[11:7] == 5'b0) begin // c.ebreak
                                instr_o = 32'h0010_0073;
                            end else begin // c.jalr
                                instr_o = {12'b0, instr_i[11:7], 3'b000, 5'b00001, OPCODE_JALR};
                            end
                        end
                    end
                    3'b101: begin // c.fsdsp
                        instr_o = {3'b0, instr_i[9:7], instr_i[12], instr_i[6:2], 5'h02, 3'b011,
                                   instr_i[11:10], 3'b000, OPCODE_STORE_FP};
                        illegal_instr_o = !HAS_FPU;
                    end
                    3'b110: begin // c.swsp
                        instr_o = {4'b0, instr_i[8:7], instr_i[12], instr_i[6:2], 5'h02, 3'b010,
                                   instr_i[11:9], 2'b00, OPCODE_STORE};
                    end
                    default: begin // c.fswsp
                        instr_o = {4'b0, instr_i[8:7], instr_i[12], instr_i[6:2], 5'h02, 3'b010,
                                   instr_i[11:9], 2'b00, OPCODE_STORE_FP};
                        illegal_instr_o = !HAS_FPU;
                    end
                endcase
            end
            default: instr_o = instr_i; // full-width instruction passes through
        endcase
    end

endmodule

// File: rtl/cv32e40p_masked_voter.sv
// rtl/cv32e40p_masked_voter.sv - L-bit N-input majority voter over a healthy mask
// Ports: data_i (N words), healthy_i (voting members), voted_o (majority word, or the
//        lowest-index healthy word when no majority), blame_o (healthy members outvoted),
//        no_majority_o, healthy_count_o (members in healthy_i).
module cv32e40p_masked_voter #(
    parameter int L = 34,
    parameter int N = 3
) (
    input  logic [N-1:0][L-1:0]       data_i,
    input  logic [N-1:0]              healthy_i,
    output logic [L-1:0]              voted_o,
    output logic [N-1:0]              blame_o,
    output logic                      no_majority_o,
    output logic [$clog2(N+1)-1:0]    healthy_count_o
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    logic [CW-1:0] count;
    logic [CW-1:0] agree;
    logic          winner_found;
    logic          first_found;
    logic [IW-1:0] winner;
    logic [IW-1:0] first;
    logic [IW-1:0] sel;

    always_comb begin
        count        = '0;
        agree        = '0;
        winner_found = 1'b0;
        first_found  = 1'b0;
        winner       = '0;
        first        = '0;
        for (int i = 0; i < N; i++) begin
            if (healthy_i[i]) count = count + 1'b1;
        end
        // A word wins when strictly more than half of the healthy members carry it.
        // Only one distinct word can satisfy that, so the lowest winning index is enough.
        for (int i = 0; i < N; i++) begin
            agree = '0;
            for (int j = 0; j < N; j++) begin
                if (healthy_i[j] && (data_i[j] == data_i[i])) agree = agree + 1'b1;
            end
            if (healthy_i[i] && !first_found) begin
                first       = IW'(i);
                first_found = 1'b1;
            end
            if (healthy_i[i] && !winner_found && ({agree, 1'b0} > {1'b0, count})) begin
                winner       = IW'(i);
                winner_found = 1'b1;
            end
        end
    end

    assign sel             = winner_found ? winner : first;
    assign voted_o         = data_i[sel];
    assign no_majority_o   = !winner_found;
    assign healthy_count_o = count;

    always_comb begin
        blame_o = '0;
        for (int j = 0; j < N; j++) begin
            blame_o[j] = winner_found && healthy_i[j] && (data_i[j] != data_i[winner]);
        end
    end

endmodule

// File: rtl/cv32e40p_compressed_decoder_nmr.sv
// rtl/cv32e40p_compressed_decoder_nmr.sv - N-modular-redundant RV32C decoder with replica retirement
// Ports: clk, rst_n (async active-low), valid_i (real fetch, gates monitors),
//        instr_i (per-replica lanes), set_broken_i / clear_broken_i (per-replica retire / repair),
//        instr_o / is_compressed_o / illegal_instr_o (voted result), uncorrectable_o,
//        is_broken_o (retirement flags), mode_o (VOTE / COMPARE / SIMPLEX / FAIL).
module cv32e40p_compressed_decoder_nmr
    import ft_pkg::*;
#(
    parameter int FPU                = 0,
    parameter int N_REP              = CDEC_NMR_N_REP,
    parameter int TIN                = 1,
    parameter int COUNT_BIT          = CDEC_NMR_COUNT_BIT,
    parameter int INCREMENT          = CDEC_NMR_INCREMENT,
    parameter int DECREMENT          = CDEC_NMR_DECREMENT,
    parameter int BREAKING_THRESHOLD = CDEC_NMR_BREAKING_THRESHOLD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_i,
    input  logic [N_REP-1:0][31:0] instr_i,
    input  logic [N_REP-1:0]       set_broken_i,
    input  logic [N_REP-1:0]       clear_broken_i,
    output logic [31:0]            instr_o,
    output logic                   is_compressed_o,
    output logic                   illegal_instr_o,
    output logic                   uncorrectable_o,
    output logic [N_REP-1:0]       is_broken_o,
    output logic [1:0]             mode_o
);

    localparam int CW = $clog2(N_REP + 1);
    localparam logic [COUNT_BIT-1:0] CNT_MAX = '1;
    localparam logic [COUNT_BIT:0]   INC_W   = (COUNT_BIT + 1)'(INCREMENT);
    localparam logic [COUNT_BIT-1:0] DEC_W   = COUNT_BIT'(DECREMENT);
    localparam logic [COUNT_BIT-1:0] THR_W   = COUNT_BIT'(BREAKING_THRESHOLD);

    logic [N_REP-1:0][33:0] tuple;
    logic [N_REP-1:0]       broken_q;
    logic [N_REP-1:0]       flag_raw;
    logic [N_REP-1:0]       flag_nxt;
    logic [N_REP-1:0]       blame;
    logic [N_REP-1:0]       auto_ret;
    logic [33:0]            voted;
    logic                   no_majority;
    logic [CW-1:0]          healthy_count;
    cdec_mode_e             mode;

    for (genvar k = 0; k < N_REP; k++) begin : g_rep
        logic [31:0]          lane;
        logic [31:0]          dec_instr;
        logic                 dec_compressed;
        logic                 dec_illegal;
        logic [COUNT_BIT-1:0] cnt_q;
        logic [COUNT_BIT-1:0] cnt_nxt;
        logic [COUNT_BIT:0]   sum;

        if (TIN != 0) begin : g_own_lane
            assign lane = instr_i[k];
        end else begin : g_shared_lane
            assign lane = instr_i[0];
        end

        cv32e40p_compressed_decoder #(
            .FPU (FPU)
        ) u_dec (
            .instr_i         (lane),
            .instr_o         (dec_instr),
            .is_compressed_o (dec_compressed),
            .illegal_instr_o (dec_illegal)
        );

        assign tuple[k] = {dec_instr, dec_compressed, dec_illegal};

        // Retired replicas and idle cycles leave the counter frozen.
        always_comb begin
            cnt_nxt = cnt_q;
            sum     = {1'b0, cnt_q} + INC_W;
            if (valid_i && !broken_q[k]) begin
                if (blame[k]) begin
                    cnt_nxt = (sum > {1'b0, CNT_MAX}) ? CNT_MAX : sum[COUNT_BIT-1:0];
                end else begin
                    cnt_nxt = (cnt_q >= DEC_W) ? (cnt_q - DEC_W) : '0;
                end
            end
        end

        assign auto_ret[k] = valid_i && !broken_q[k] && (cnt_nxt >= THR_W);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (clear_broken_i[k] && !set_broken_i[k]) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_nxt;
            end
        end
    end

    if (TIN == 0) begin : g_unused_lanes
        logic unused_lanes;
        assign unused_lanes = ^instr_i;
    end

    cv32e40p_masked_voter #(
        .L (34),
        .N (N_REP)
    ) u_voter (
        .data_i          (tuple),
        .healthy_i       (~broken_q),
        .voted_o         (voted),
        .blame_o         (blame),
        .no_majority_o   (no_majority),
        .healthy_count_o (healthy_count)
    );

    // Automatic retirements that would leave no healthy replica are dropped for the
    // cycle; forced retirements always land, even if they empty the pool.
    always_comb begin
        flag_raw = set_broken_i | (~clear_broken_i & (broken_q | auto_ret));
        flag_nxt = flag_raw;
        if (&flag_raw) flag_nxt = set_broken_i | (~clear_broken_i & broken_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            broken_q <= '0;
        end else begin
            broken_q <= flag_nxt;
        end
    end

    assign mode        = cdec_mode_from_healthy(32'(healthy_count));
    assign mode_o      = mode;
    assign is_broken_o = broken_q;

    // With no healthy replica the output is forced to an illegal instruction so the core traps.
    always_comb begin
        instr_o         = voted[33:2];
        is_compressed_o = voted[1];
        illegal_instr_o = voted[0];
        uncorrectable_o = no_majority;
        if (mode == CDEC_FAIL) begin
            instr_o         = '0;
            is_compressed_o = 1'b0;
            illegal_instr_o = 1'b1;
            uncorrectable_o = 1'b1;
        end
    end

endmodule
